// File: rtl/uart_fifo_port.sv
// UART with TX/RX FIFOs behind a 4-register host port; bit period is DIVISOR+1 clocks.
// Optional RTS/CTS flow control is compiled in with UART_FLOW_CTRL_EN.
module uart_fifo_port #(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    input  logic        rxd,
    output logic        txd,
    input  logic        cts_n,
    output logic        rts_n
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS-1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [15:0]          div_q;
    logic [1:0]           ctrl_q;
    logic                 ovr_q, ferr_q, irq_q;
    logic [31:0]          rdata_q, rd_mux, rx_word;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0]          tx_cnt_q, rx_cnt_q;
    logic                 rxd_s1_q, rxd_s2_q, rx_prev_q;

    state_t               tx_state_q, rx_state_q;
    logic                 txd_q;
    logic [15:0]          tx_tmr_q, tx_len_q, rx_tmr_q, rx_len_q;
    logic [2:0]           tx_idx_q, rx_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q, rx_shift_q;

    logic tx_full, tx_empty, rx_full, rx_empty, tx_busy, cts_ok;
    logic wr_data, wr_stat, tx_push, tx_pop, host_pop;
    logic rx_done, rx_push, rx_ovr_set, rx_ferr_set;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_busy  = (tx_state_q != S_IDLE);

    assign wr_data  = avs_write && (avs_address == 2'd0);
    assign wr_stat  = avs_write && (avs_address == 2'd1);
    assign tx_push  = wr_data && !tx_full;
    assign tx_pop   = (tx_state_q == S_IDLE) && !tx_empty && cts_ok;
    assign host_pop = avs_read && (avs_address == 2'd0) && !rx_empty;

    // A full RX FIFO still accepts a character when the host pops in the same cycle.
    assign rx_done     = (rx_state_q == S_STOP) && (rx_tmr_q == '0);
    assign rx_push     = rx_done && rxd_s2_q && (!rx_full || host_pop);
    assign rx_ovr_set  = rx_done && rxd_s2_q && rx_full && !host_pop;
    assign rx_ferr_set = rx_done && !rxd_s2_q;

`ifdef UART_FLOW_CTRL_EN
    localparam logic [AW:0] RTS_LVL = (AW+1)'(FIFO_DEPTH-2);
    logic cts_s1_q, cts_s2_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            cts_s1_q <= cts_n;
            cts_s2_q <= cts_s1_q;
        end
    end
    assign cts_ok = !cts_s2_q;
    assign rts_n  = (rx_cnt_q >= RTS_LVL);
    logic unused_bits;
    assign unused_bits = ^avs_writedata[31:16];
`else
    assign cts_ok = 1'b1;
    assign rts_n  = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:16], cts_n};
`endif

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= avs_writedata[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
            if (rx_push)  rx_wp_q <= rx_wp_q + 1'b1;
            if (host_pop) rx_rp_q <= rx_rp_q + 1'b1;
            if (rx_push && !host_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
            else if (!rx_push && host_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
        end
    end

    always_comb begin
        rx_word = '0;
        if (!rx_empty) begin
            rx_word[DATA_BITS-1:0] = rx_mem[rx_rp_q];
            rx_word[15]            = 1'b1;
        end
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux = rx_word;
            2'd1: rd_mux = {9'b0, 7'(rx_cnt_q), 9'b0, tx_busy, ferr_q, ovr_q,
                            rx_empty, rx_full, tx_empty, tx_full};
            2'd2: rd_mux = {30'b0, ctrl_q};
            2'd3: rd_mux = {16'b0, div_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= DIV_RESET;
            ctrl_q  <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (avs_write && avs_address == 2'd2) ctrl_q <= avs_writedata[1:0];
            if (avs_write && avs_address == 2'd3) div_q  <= avs_writedata[15:0];
            // Set beats write-1-to-clear so an event in the clearing cycle is not lost.
            ovr_q  <= rx_ovr_set  || (ovr_q  && !(wr_stat && avs_writedata[4]));
            ferr_q <= rx_ferr_set || (ferr_q && !(wr_stat && avs_writedata[5]));
            if (avs_read) rdata_q <= rd_mux;
            irq_q <= (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty) || ovr_q || ferr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            txd_q      <= 1'b1;
            tx_tmr_q   <= '0;
            tx_len_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_pop) begin
                        tx_state_q <= S_START;
                        txd_q      <= 1'b0;
                        tx_tmr_q   <= div_q;
                        tx_len_q   <= div_q;
                        tx_shift_q <= tx_mem[tx_rp_q];
                    end
                end
                S_START: begin
                    if (tx_tmr_q == '0) begin
                        tx_state_q <= S_DATA;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_tmr_q   <= tx_len_q;
                        tx_idx_q   <= '0;
                    end else tx_tmr_q <= tx_tmr_q - 1'b1;
                end
                S_DATA: begin
                    if (tx_tmr_q == '0) begin
                        tx_tmr_q <= tx_len_q;
                        if (tx_idx_q == LAST_BIT) begin
                            tx_state_q <= S_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + 1'b1;
                        end
                    end else tx_tmr_q <= tx_tmr_q - 1'b1;
                end
                S_STOP: begin
                    if (tx_tmr_q == '0) tx_state_q <= S_IDLE;
                    else                tx_tmr_q   <= tx_tmr_q - 1'b1;
                end
            endcase
        end
    end

    // Start detection needs a high-to-low edge, so after a framing error the line must return high first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tmr_q   <= '0;
            rx_len_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rxd_s1_q  <= rxd;
            rxd_s2_q  <= rxd_s1_q;
            rx_prev_q <= rxd_s2_q;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rxd_s2_q) begin
                        rx_state_q <= S_START;
                        rx_len_q   <= div_q;
                        rx_tmr_q   <= div_q >> 1;
                    end
                end
                S_START: begin
                    if (rx_tmr_q == '0) begin
                        rx_state_q <= rxd_s2_q ? S_IDLE : S_DATA;
                        rx_tmr_q   <= rx_len_q;
                        rx_idx_q   <= '0;
                    end else rx_tmr_q <= rx_tmr_q - 1'b1;
                end
                S_DATA: begin
                    if (rx_tmr_q == '0) begin
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_tmr_q   <= rx_len_q;
                        if (rx_idx_q == LAST_BIT) rx_state_q <= S_STOP;
                        else                      rx_idx_q   <= rx_idx_q + 1'b1;
                    end else rx_tmr_q <= rx_tmr_q - 1'b1;
                end
                S_STOP: begin
                    if (rx_tmr_q == '0) rx_state_q <= S_IDLE;
                    else                rx_tmr_q   <= rx_tmr_q - 1'b1;
                end
            endcase
        end
    end

    assign txd          = txd_q;
    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_uart_fifo_port.sv
// Scoreboard bench for uart_fifo_port (FIFO_DEPTH = 4, 8-bit characters).
`timescale 1ns/1ps
module tb_uart_fifo_port;
    localparam int DEPTH = 4;
`ifdef UART_FLOW_CTRL_EN
    localparam logic FLOW = 1'b1;
`else
    localparam logic FLOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq, txd, rts_n;
    logic        rxd = 1'b1;
    logic        cts_n = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_port #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .rxd(rxd), .txd(txd), .cts_n(cts_n), .rts_n(rts_n));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];
    logic       ovr_m = 1'b0;
    logic       ferr_m = 1'b0;
    logic [1:0] ctrl_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    function automatic logic [31:0] status_model();
        int n = rx_sb.size();
        return {9'b0, 7'(n), 9'b0, 1'b0, ferr_m, ovr_m, n == 0, n == DEPTH, 1'b1, 1'b0};
    endfunction

    function automatic logic irq_model();
        return (ctrl_m[0] && rx_sb.size() != 0) || ctrl_m[1] || ovr_m || ferr_m;
    endfunction

    task automatic rx_send(input logic [7:0] b, input logic stop, input int period);
        logic [9:0] frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            repeat (period - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (2 * period) @(negedge clk);
    endtask

    task automatic rx_expect(input logic [7:0] b);
        rx_send(b, 1'b1, 4);
        if (rx_sb.size() < DEPTH) rx_sb.push_back(b);
        else ovr_m = 1'b1;
    endtask

    task automatic rx_read_check(input string tag);
        logic [31:0] d, exp;
        exp = '0;
        bus_read(2'd0, d);
        if (rx_sb.size() > 0) exp = 32'h8000 | 32'(rx_sb.pop_front());
        check(tag, d, exp);
    endtask

    task automatic status_check(input string tag);
        logic [31:0] d;
        bus_read(2'd1, d);
        check(tag, d, status_model());
    endtask

    // Called on the first negedge where txd is low; verifies every sample of the frame.
    task automatic tx_frame(input int period);
        logic [7:0] exp_b, got_b;
        logic [9:0] frame;
        int         bad = 0;
        exp_b = tx_sb.pop_front();
        frame = {1'b1, exp_b, 1'b0};
        got_b = '0;
        for (int j = 0; j < 10 * period; j++) begin
            if (j > 0) @(negedge clk);
            if (txd !== frame[j / period]) bad++;
            if (j % period == period / 2 && j / period >= 1 && j / period <= 8)
                got_b[j / period - 1] = txd;
        end
        check("tx_byte", 32'(got_b), 32'(exp_b));
        check("tx_bit_timing", bad, 0);
    endtask

    task automatic tx_capture(input int period);
        logic started = 1'b0;
        for (int c = 0; c < 400 && !started; c++) begin
            @(negedge clk);
            started = (txd == 1'b0);
        end
        check("tx_start_seen", 32'(started), 1);
        if (started) tx_frame(period);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lows, lat;

        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_rts_n", 32'(rts_n), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_readdata", avs_readdata, 0);
        reset_n = 1'b1;
        status_check("rst_status");
        bus_read(2'd3, d); check("rst_divisor", d, 433);
        bus_read(2'd2, d); check("rst_control", d, 0);

        bus_write(2'd3, 32'd3);
        bus_read(2'd3, d); check("divisor_rb", d, 3);

        tx_sb.push_back(8'hA5);
        bus_write(2'd0, 32'hA5);
        tx_capture(4);
        repeat (2) @(negedge clk);
        status_check("tx_done_status");

        rx_expect(8'h3C);
        status_check("rx_one_status");
        rx_read_check("rx_3c");
        rx_read_check("rx_empty_read");

        foreach (tx_sb[i]) tx_sb.delete(i);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i < 5) tx_sb.push_back(8'(8'h10 * i + 8'h0F));
                    bus_write(2'd0, 32'(8'h10 * i + 8'h0F));
                end
                bus_read(2'd1, d); check("tx_full_status", d, 32'h0000_0049);
            end
            repeat (5) tx_capture(4);
        join
        lows = 0;
        repeat (60) begin @(negedge clk); if (txd == 1'b0) lows++; end
        check("tx_drop_no_frame", lows, 0);

        for (int i = 1; i <= 5; i++) rx_expect(8'(8'h11 * i));
        status_check("ovr_status");
        check("ovr_irq", 32'(irq), 32'(irq_model()));
        for (int i = 0; i < 5; i++) rx_read_check("ovr_read");
        bus_write(2'd1, 32'h10); ovr_m = 1'b0;
        repeat (2) @(negedge clk);
        status_check("ovr_cleared");
        check("ovr_irq_clr", 32'(irq), 32'(irq_model()));

        rx_send(8'h5A, 1'b0, 4); ferr_m = 1'b1;
        status_check("ferr_status");
        check("ferr_irq", 32'(irq), 32'(irq_model()));
        rx_expect(8'h96);
        rx_read_check("after_ferr");
        bus_write(2'd1, 32'h20); ferr_m = 1'b0;
        status_check("ferr_cleared");

        bus_write(2'd2, 32'h2); ctrl_m = 2'b10;
        bus_read(2'd2, d); check("control_rb", d, 2);
        check("irq_tx_ie", 32'(irq), 32'(irq_model()));
        bus_write(2'd2, 32'h1); ctrl_m = 2'b01;
        repeat (2) @(negedge clk);
        check("irq_rx_ie_idle", 32'(irq), 32'(irq_model()));
        rx_expect(8'h77);
        check("irq_rx_ie_data", 32'(irq), 32'(irq_model()));
        rx_read_check("irq_rx_read");
        repeat (2) @(negedge clk);
        check("irq_rx_ie_popped", 32'(irq), 32'(irq_model()));
        bus_write(2'd2, 32'h0); ctrl_m = 2'b00;

        fork
            begin
                tx_sb.push_back(8'hC3); bus_write(2'd0, 32'hC3);
                tx_sb.push_back(8'h3A); bus_write(2'd0, 32'h3A);
                repeat (10) @(negedge clk);
                bus_write(2'd3, 32'd7);
            end
            begin
                tx_capture(4);
                tx_capture(8);
            end
        join
        bus_write(2'd3, 32'd3);

        cts_n = 1'b1;
        tx_sb.push_back(8'h5C);
        bus_write(2'd0, 32'h5C);
`ifdef UART_FLOW_CTRL_EN
        lows = 0;
        repeat (60) begin @(negedge clk); if (txd == 1'b0) lows++; end
        check("cts_hold", lows, 0);
        cts_n = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (txd == 1'b0) lat = c;
        end
        check("cts_release_lat", 32'(lat >= 1 && lat <= 3), 1);
        if (lat != 0) tx_frame(4);
`else
        tx_capture(4);
        cts_n = 1'b0;
`endif
        rx_expect(8'hE1);
        check("rts_one", 32'(rts_n), 0);
        rx_expect(8'h1E);
        check("rts_two", 32'(rts_n), 32'(FLOW));
        rx_read_check("rts_read0");
        rx_read_check("rts_read1");
        check("rts_drained", 32'(rts_n), 0);

        bus_write(2'd0, 32'hF0);
        repeat (12) @(negedge clk);
        check("mid_frame_low", 32'(txd), 0);
        #2 reset_n = 1'b0;
        #1 check("async_reset_txd", 32'(txd), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ovr_m = 1'b0; ferr_m = 1'b0; ctrl_m = '0;
        bus_read(2'd3, d); check("div_after_reset", d, 433);
        status_check("status_after_reset");
        lows = 0;
        repeat (50) begin @(negedge clk); if (txd == 1'b0) lows++; end
        check("no_tx_after_reset", lows, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
